// File: rtl/mips_control_immediate_pipe.sv
// Registered immediate-generation stage for the decode/execute boundary.
// It extends the raw immediate (sign or zero) and then shifts it left by 0, 2, 16 or 32.
// The operand travels behind a valid/ready handshake with a one-entry skid buffer.
// The stage also has a flush input and a saturating transfer counter.
module mips_control_immediate_pipe #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned IMM_WIDTH   = 16,
  parameter int unsigned TAG_WIDTH   = 5,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IMM_WIDTH-1:0]   in_imm,
  input  logic                   in_extend,
  input  logic [1:0]             in_shift,
  input  logic [TAG_WIDTH-1:0]   in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [TAG_WIDTH-1:0]   out_tag,
  output logic                   out_illegal,
  output logic [COUNT_WIDTH-1:0] transfer_count
);

  // Encoding mirrors {out_valid, skid_valid}.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StHold  = 2'b10,
    StFull  = 2'b11
  } state_e;

  state_e                 state_q, state_d;
  logic                   in_ready_q;
  logic                   accept, transfer;
  logic                   load_out_in, load_out_skid, load_skid;
  logic [DATA_WIDTH-1:0]  ext_imm, imm_data;
  logic                   imm_illegal;
  logic [DATA_WIDTH-1:0]  out_data_q, skid_data_q;
  logic [TAG_WIDTH-1:0]   out_tag_q, skid_tag_q;
  logic                   out_illegal_q, skid_illegal_q;
  logic [COUNT_WIDTH-1:0] count_q;

  assign transfer = (state_q != StEmpty) & out_ready;
  // Flush drops any same-cycle input.
  assign accept   = in_valid & in_ready_q & ~flush;

  assign ext_imm = in_extend ? {{(DATA_WIDTH-IMM_WIDTH){1'b0}}, in_imm}
                             : {{(DATA_WIDTH-IMM_WIDTH){in_imm[IMM_WIDTH-1]}}, in_imm};

  // Shift the extended immediate; Left32 has no meaning for a 32-bit operand.
  always_comb begin
    imm_data    = ext_imm;
    imm_illegal = 1'b0;
    unique case (in_shift)
      2'd0: imm_data = ext_imm;
      2'd1: imm_data = ext_imm << 2;
      2'd2: imm_data = ext_imm << 16;
      default: begin
        if (DATA_WIDTH > 32) begin
          imm_data = ext_imm << 32;
        end else begin
          imm_data    = '0;
          imm_illegal = 1'b1;
        end
      end
    endcase
  end

  // Handshake next-state and register load enables.
  always_comb begin
    state_d       = state_q;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d     = StHold;
            load_out_in = 1'b1;
          end
        end
        StHold: begin
          if (transfer && accept) begin
            load_out_in = 1'b1;
          end else if (transfer) begin
            state_d = StEmpty;
          end else if (accept) begin
            state_d   = StFull;
            load_skid = 1'b1;
          end
        end
        StFull: begin
          if (transfer) begin
            state_d       = StHold;
            load_out_skid = 1'b1;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  // State and registered in_ready; ready is derived from next state, never from out_ready.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != StFull);
    end
  end

  // Output register: loads from the input path or from the skid entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_data_q    <= '0;
      out_tag_q     <= '0;
      out_illegal_q <= 1'b0;
    end else if (load_out_in) begin
      out_data_q    <= imm_data;
      out_tag_q     <= in_tag;
      out_illegal_q <= imm_illegal;
    end else if (load_out_skid) begin
      out_data_q    <= skid_data_q;
      out_tag_q     <= skid_tag_q;
      out_illegal_q <= skid_illegal_q;
    end
  end

  // Skid register: captures an accepted operand while the output is stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      skid_data_q    <= '0;
      skid_tag_q     <= '0;
      skid_illegal_q <= 1'b0;
    end else if (load_skid) begin
      skid_data_q    <= imm_data;
      skid_tag_q     <= in_tag;
      skid_illegal_q <= imm_illegal;
    end
  end

  // Saturating count of completed output transfers; flushed transfers do not count.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else if (transfer && !flush && !(&count_q)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = (state_q != StEmpty);
  assign out_data       = out_data_q;
  assign out_tag        = out_tag_q;
  assign out_illegal    = out_illegal_q;
  assign transfer_count = count_q;

endmodule

// File: tb/tb_mips_control_immediate_pipe.sv
// Bench for mips_control_immediate_pipe.
// Two instances share one stimulus: a 32-bit one and a 64-bit one with a 2-bit counter.
// A queue-based reference model predicts the handshake, the data and the counts.
module tb_mips_control_immediate_pipe;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, flush, in_valid, out_ready, in_extend;
  logic [15:0] in_imm;
  logic [1:0]  in_shift;
  logic [4:0]  in_tag;

  logic        a_in_ready, a_out_valid, a_out_illegal;
  logic [31:0] a_out_data;
  logic [4:0]  a_out_tag;
  logic [15:0] a_count;

  logic        b_in_ready, b_out_valid, b_out_illegal;
  logic [63:0] b_out_data;
  logic [4:0]  b_out_tag;
  logic [1:0]  b_count;

  mips_control_immediate_pipe #(
    .DATA_WIDTH(32), .IMM_WIDTH(16), .TAG_WIDTH(5), .COUNT_WIDTH(16)
  ) dut_a (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_imm(in_imm), .in_extend(in_extend), .in_shift(in_shift), .in_tag(in_tag),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data), .out_tag(a_out_tag),
    .out_illegal(a_out_illegal), .transfer_count(a_count)
  );

  mips_control_immediate_pipe #(
    .DATA_WIDTH(64), .IMM_WIDTH(16), .TAG_WIDTH(5), .COUNT_WIDTH(2)
  ) dut_b (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_imm(in_imm), .in_extend(in_extend), .in_shift(in_shift), .in_tag(in_tag),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data), .out_tag(b_out_tag),
    .out_illegal(b_out_illegal), .transfer_count(b_count)
  );

  typedef struct packed {
    logic [15:0] imm;
    logic        ext;
    logic [1:0]  sh;
    logic [4:0]  tag;
  } item_t;

  item_t       q[$];
  bit          m_ready;
  int unsigned m_cnt_a, m_cnt_b;
  int          checks = 0;
  int          errors = 0;

  // Expected operand from the extend/shift rules, truncated to the operand width.
  function automatic logic [63:0] ref_imm(input item_t it, input int w);
    logic [63:0] v;
    int          sa;
    v  = it.ext ? {48'd0, it.imm} : {{48{it.imm[15]}}, it.imm};
    sa = (it.sh == 2'd0) ? 0 : (it.sh == 2'd1) ? 2 : (it.sh == 2'd2) ? 16 : 32;
    v  = v << sa;
    if (w == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit    acc;
    item_t it;
    if (reset) begin
      q.delete();
      m_ready = 1'b0;
      m_cnt_a = 0;
      m_cnt_b = 0;
    end else if (flush) begin
      q.delete();
      m_ready = 1'b1;
    end else begin
      acc = in_valid && m_ready;
      if (q.size() > 0 && out_ready) begin
        void'(q.pop_front());
        if (m_cnt_a < 65535) m_cnt_a++;
        if (m_cnt_b < 3) m_cnt_b++;
      end
      if (acc) begin
        it.imm = in_imm;
        it.ext = in_extend;
        it.sh  = in_shift;
        it.tag = in_tag;
        q.push_back(it);
      end
      m_ready = (q.size() < 2);
    end
  endtask

  task automatic check_outputs();
    chk("a_out_valid", 64'(a_out_valid), 64'(q.size() > 0));
    chk("b_out_valid", 64'(b_out_valid), 64'(q.size() > 0));
    chk("a_in_ready", 64'(a_in_ready), 64'(m_ready));
    chk("b_in_ready", 64'(b_in_ready), 64'(m_ready));
    chk("a_count", 64'(a_count), 64'(m_cnt_a));
    chk("b_count", 64'(b_count), 64'(m_cnt_b));
    if (q.size() > 0) begin
      chk("a_data", 64'(a_out_data), ref_imm(q[0], 32));
      chk("b_data", b_out_data, ref_imm(q[0], 64));
      chk("a_tag", 64'(a_out_tag), 64'(q[0].tag));
      chk("b_tag", 64'(b_out_tag), 64'(q[0].tag));
      chk("a_illegal", 64'(a_out_illegal), 64'(q[0].sh == 2'd3));
      chk("b_illegal", 64'(b_out_illegal), 64'd0);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clock);
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic v, input logic [15:0] imm, input logic ext,
                       input logic [1:0] sh, input logic [4:0] tag);
    in_valid  = v;
    in_imm    = imm;
    in_extend = ext;
    in_shift  = sh;
    in_tag    = tag;
  endtask

  task automatic chk_zero_outputs(input string name);
    chk({name, "_a_data"}, 64'(a_out_data), 64'd0);
    chk({name, "_b_data"}, b_out_data, 64'd0);
    chk({name, "_a_tag"}, 64'(a_out_tag), 64'd0);
    chk({name, "_a_illegal"}, 64'(a_out_illegal), 64'd0);
    chk({name, "_b_illegal"}, 64'(b_out_illegal), 64'd0);
  endtask

  int unsigned base;

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 2'd0, 5'd0);
    step();
    step();
    chk_zero_outputs("reset");
    reset = 1'b0;
    step();
    chk("ready_after_reset", 64'(a_in_ready), 64'd1);

    // Extension and shift modes, back-to-back with out_ready held high.
    drive(1'b1, 16'h8001, 1'b0, 2'd0, 5'd1); step();
    chk("sext32", 64'(a_out_data), 64'hFFFF_8001);
    chk("sext64", b_out_data, 64'hFFFF_FFFF_FFFF_8001);
    drive(1'b1, 16'h8001, 1'b1, 2'd0, 5'd2); step();
    chk("zext32", 64'(a_out_data), 64'h0000_8001);
    drive(1'b1, 16'h1234, 1'b1, 2'd2, 5'd3); step();
    chk("lui32", 64'(a_out_data), 64'h1234_0000);
    drive(1'b1, 16'hFFFF, 1'b0, 2'd1, 5'd4); step();
    chk("br32", 64'(a_out_data), 64'hFFFF_FFFC);
    drive(1'b1, 16'h8000, 1'b0, 2'd3, 5'd5); step();
    chk("l32_64", b_out_data, 64'hFFFF_8000_0000_0000);
    chk("l32_64_illegal", 64'(b_out_illegal), 64'd0);
    chk("l32_32", 64'(a_out_data), 64'd0);
    chk("l32_32_illegal", 64'(a_out_illegal), 64'd1);
    drive(1'b0, 16'h0, 1'b0, 2'd0, 5'd0); step();

    // Backpressure: tag 3 must wait upstream while the skid holds tag 2.
    out_ready = 1'b0;
    base = m_cnt_a;
    drive(1'b1, 16'h0011, 1'b0, 2'd0, 5'd1); step();
    drive(1'b1, 16'h0022, 1'b0, 2'd0, 5'd2); step();
    chk("bp_ready_low", 64'(a_in_ready), 64'd0);
    drive(1'b1, 16'h0033, 1'b0, 2'd0, 5'd3); step(); step();
    chk("bp_head_tag", 64'(a_out_tag), 64'd1);
    out_ready = 1'b1;
    step();
    chk("bp_second_tag", 64'(a_out_tag), 64'd2);
    step();
    chk("bp_third_tag", 64'(a_out_tag), 64'd3);
    drive(1'b0, 16'h0, 1'b0, 2'd0, 5'd0); step();
    chk("bp_count3", 64'(a_count), 64'(base + 3));

    // Full throughput for 10 cycles.
    base = m_cnt_a;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 16'($urandom), 1'($urandom), 2'($urandom), 5'(i));
      step();
      chk("tput_ready", 64'(a_in_ready), 64'd1);
    end
    drive(1'b0, 16'h0, 1'b0, 2'd0, 5'd0); step();
    chk("tput_count", 64'(a_count), 64'(base + 10));

    // Flush while FULL with a same-cycle input and transfer.
    out_ready = 1'b0;
    drive(1'b1, 16'h0101, 1'b0, 2'd0, 5'd7); step();
    drive(1'b1, 16'h0202, 1'b0, 2'd0, 5'd8); step();
    base = m_cnt_a;
    flush = 1'b1; out_ready = 1'b1;
    drive(1'b1, 16'h0303, 1'b0, 2'd0, 5'd9); step();
    flush = 1'b0;
    chk("flush_valid", 64'(a_out_valid), 64'd0);
    chk("flush_ready", 64'(a_in_ready), 64'd1);
    chk("flush_count", 64'(a_count), 64'(base));
    drive(1'b1, 16'h0404, 1'b1, 2'd0, 5'd10); step();
    chk("post_flush_valid", 64'(a_out_valid), 64'd1);
    chk("post_flush_data", 64'(a_out_data), 64'h0000_0404);
    drive(1'b0, 16'h0, 1'b0, 2'd0, 5'd0); step();

    // Reset while FULL, then counter saturation on the 2-bit instance.
    out_ready = 1'b0;
    drive(1'b1, 16'h0505, 1'b0, 2'd0, 5'd11); step();
    drive(1'b1, 16'h0606, 1'b0, 2'd0, 5'd12); step();
    reset = 1'b1; step();
    chk("rst_full_ready", 64'(a_in_ready), 64'd0);
    chk("rst_full_valid", 64'(a_out_valid), 64'd0);
    chk_zero_outputs("rst_full");
    reset = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 2'd0, 5'd0); step();
    chk("rst_release_ready", 64'(a_in_ready), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'($urandom), 1'($urandom), 2'($urandom), 5'(i));
      step();
    end
    drive(1'b0, 16'h0, 1'b0, 2'd0, 5'd0); step();
    chk("sat_b_count", 64'(b_count), 64'd3);
    chk("sat_a_count", 64'(a_count), 64'd5);

    // Randomised traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom), 2'($urandom),
            5'($urandom));
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      reset     = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0; flush = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_control_immediate_pipe.md
Name: mips_control_immediate_pipe

Overview:
Parametrised, registered immediate-generation stage for the decode/execute boundary. It takes decoded extend/shift controls plus the raw 16-bit immediate, and produces a DATA_WIDTH-wide immediate operand. The operand is carried behind a valid/ready handshake with a one-entry skid buffer, a flush input, and a saturating transfer counter. Compared with the combinational extend/shift decision, it adds branch-offset and 32-bit shift modes, width generalisation, backpressure and flush.

Parameters:
DATA_WIDTH, 32, width of produced immediate; legal values 32 or 64
IMM_WIDTH, 16, width of raw instruction immediate field
TAG_WIDTH, 5, width of sideband tag (destination register id) carried with each operand
COUNT_WIDTH, 16, width of saturating transfer counter

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  drop all held and incoming operands this cycle
in_valid  input  1  upstream offers an operand
in_ready  output  1  stage can accept; registered
in_imm  input  IMM_WIDTH  raw immediate field
in_extend  input  1  0 = Signed, 1 = Unsigned (zero)
in_shift  input  2  0 = None, 1 = Left2 (branch offset), 2 = Left16 (lui), 3 = Left32
in_tag  input  TAG_WIDTH  sideband tag
out_valid  output  1  operand available
out_ready  input  1  downstream accepts
out_data  output  DATA_WIDTH  extended and shifted immediate
out_tag  output  TAG_WIDTH  tag of out_data
out_illegal  output  1  operand used a shift mode illegal for DATA_WIDTH
transfer_count  output  COUNT_WIDTH  number of completed output transfers

Behaviour:
- Reset (reset=1 at edge): out_valid=0, out_data=0, out_tag=0, out_illegal=0, skid empty, transfer_count=0. in_ready is 0 while reset is asserted and 1 from the first cycle after deassertion.
- Compute, combinational on input side:
  - Extend in_imm to DATA_WIDTH: sign-extend if in_extend=0, zero-extend if 1.
  - Then shift left by 0, 2, 16 or 32 per in_shift; bits shifted past DATA_WIDTH-1 are discarded.
  - Left32 with DATA_WIDTH=32: result all zeros and out_illegal=1.
  - out_illegal=0 in every other case.
- Latency: exactly 1 cycle from accepted input (in_valid & in_ready) to out_valid, when the output register is empty or draining.
- Handshake states, held in registers {out_valid, skid_valid}:
  - EMPTY (0,0): an accept loads the output register, giving HOLD.
  - HOLD (1,0):
    - Output transfer with no accept returns to EMPTY.
    - Transfer with accept reloads the output register and stays in HOLD.
    - Accept without transfer loads the skid register, giving FULL.
  - FULL (1,1): in_ready=0. On output transfer the skid moves to the output register, giving HOLD.
- in_ready = ~skid_valid, registered; never combinationally dependent on out_ready.
- Output fields (out_data/out_tag/out_illegal) stay stable while out_valid=1 and out_ready=0.
- Flush: highest priority after reset.
  - Next cycle out_valid=0 and the skid is empty.
  - Any same-cycle input is dropped.
  - A same-cycle output transfer is not counted.
  - in_ready is 1 the next cycle.
- transfer_count increments by 1 on each out_valid & out_ready cycle not coinciding with flush. It saturates at all ones and never wraps.
- reset has priority over flush and over all handshake activity.

Test Plan:
- Sign and zero extend:
  - DATA_WIDTH=32, in_imm=0x8001, extend=0, shift=0 -> out_data=0xFFFF8001 one cycle later.
  - extend=1 -> 0x00008001.
- Shift modes:
  - in_imm=0x1234, extend=1, shift=2 -> 0x12340000.
  - in_imm=0xFFFF, extend=0, shift=1 -> 0xFFFFFFFC.
  - DATA_WIDTH=64, in_imm=0x8000, extend=0, shift=3 -> 0xFFFF800000000000, out_illegal=0.
  - DATA_WIDTH=32, shift=3 -> out_data=0, out_illegal=1.
- Backpressure and skid:
  - out_ready=0, stream tags 1,2,3 -> in_ready falls to 0 after tag 2 is accepted; tag 3 is held upstream.
  - Raise out_ready -> tags 1,2,3 appear in order with no loss or duplication; transfer_count=3.
- Full throughput: out_ready=1, in_valid=1 for 10 cycles -> 10 transfers on consecutive cycles, in_ready constantly 1, transfer_count=10.
- Flush in FULL with in_valid=1 and out_ready=1 the same cycle -> next cycle out_valid=0, in_ready=1, transfer_count unchanged; a new input then yields out_valid one cycle later.
- Reset mid-stream while FULL -> all outputs 0 and in_ready=0 during reset, in_ready=1 the cycle after. COUNT_WIDTH=2 with 5 transfers -> transfer_count saturates at 3.
